// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexing controller for a 4-digit 7-segment display. It walks a
// 2-bit digit select through 0..3 and produces the matching active-low anode
// enables and decimal point. Each slot opens with a short all-dark guard
// window to suppress ghosting. Digits that are flagged in blink_mask go dark
// while blink_phase is 1.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           display enable (0 = all anodes off, counters frozen)
//   blink_mask   bit i = digit i blinks
//   dp_mask      bit i = decimal point lit on digit i
//   sel          current digit index to the digit mux (0..3)
//   an           anode enables, active-low, bit i = digit i
//   dp           decimal point, active-low
//   digit_tick   one-cycle pulse on the first cycle of each new slot
//   blink_phase  current blink phase (1 = blinking digits dark)
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       dp,
    output logic       digit_tick,
    output logic       blink_phase
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // State registers
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [1:0]       sel_reg,   sel_next;
    logic [FRM_W-1:0] frame_reg, frame_next;
    logic             phase_reg, phase_next;
    logic             tick_reg,  tick_next;

    // Registered copies of the inputs
    logic             en_q;
    logic [3:0]       blink_q;
    logic [3:0]       dp_q;

    // Registered outputs
    logic [3:0]       an_reg,    an_next;
    logic             dp_reg,    dp_next;

    // Prescaler, slot counter and frame/blink counter
    always_comb begin
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        frame_next = frame_reg;
        phase_next = phase_reg;
        tick_next  = 1'b0;
        if (en_q) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next  = '0;
                sel_next  = sel_reg + 2'd1;
                tick_next = 1'b1;
                // Leaving slot 3 closes a full frame
                if (sel_reg == 2'd3) begin
                    if (frame_reg == FRM_LAST) begin
                        frame_next = '0;
                        phase_next = ~phase_reg;
                    end else begin
                        frame_next = frame_reg + 1'b1;
                    end
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // The outputs are registered from the next-state values, and the raw
    // inputs act as the next values of en_q/blink_q/dp_q. As a result an/dp
    // always match the sel/cnt/phase that are visible in the same cycle.
    logic guard_next;
    logic lit_next;

    always_comb begin
        guard_next = (int'(cnt_next) < GUARD);
        lit_next   = en && !guard_next && !(blink_mask[sel_next] && phase_next);
        dp_next    = ~(lit_next && dp_mask[sel_next]);
    end

    // One-hot anode decode: at most one bit can be low, because sel_next
    // selects exactly one digit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_next[gi] = ~(lit_next && (sel_next == 2'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            sel_reg   <= 2'd0;
            frame_reg <= '0;
            phase_reg <= 1'b0;
            tick_reg  <= 1'b0;
            en_q      <= 1'b0;
            blink_q   <= 4'd0;
            dp_q      <= 4'd0;
            an_reg    <= 4'b1111;
            dp_reg    <= 1'b1;
        end else begin
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            frame_reg <= frame_next;
            phase_reg <= phase_next;
            tick_reg  <= tick_next;
            en_q      <= en;
            blink_q   <= blink_mask;
            dp_q      <= dp_mask;
            an_reg    <= an_next;
            dp_reg    <= dp_next;
        end
    end

    assign sel         = sel_reg;
    assign an          = an_reg;
    assign dp          = dp_reg;
    assign digit_tick  = tick_reg;
    assign blink_phase = phase_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Checks display_scan_ctrl against a slot-arithmetic model. The model derives
// every output from the count of enabled cycles n:
//   cnt   = n % SCAN_DIV
//   slot  = n / SCAN_DIV
//   sel   = slot % 4
//   phase = (slot / 4 / BLINK_FRAMES) % 2
// A hand-computed directed sequence pins this model. A second instance uses
// a longer slot length; the bench checks its digit_tick period and confirms
// that it never drives more than one anode low.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int SD = 4;
    localparam int G  = 1;
    localparam int BF = 2;
    localparam int SD2 = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] blink_mask;
    logic [3:0] dp_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic       dp;
    logic       digit_tick;
    logic       blink_phase;

    logic       rst2_n;
    logic [1:0] sel2;
    logic [3:0] an2;
    logic       dp2;
    logic       tick2;
    logic       phase2;

    always #5 clk = ~clk;

    display_scan_ctrl #(.SCAN_DIV(SD), .GUARD(G), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .blink_mask(blink_mask),
        .dp_mask(dp_mask), .sel(sel), .an(an), .dp(dp),
        .digit_tick(digit_tick), .blink_phase(blink_phase)
    );

    display_scan_ctrl #(.SCAN_DIV(SD2), .GUARD(2), .BLINK_FRAMES(3)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(1'b1), .blink_mask(4'b1010),
        .dp_mask(4'b0000), .sel(sel2), .an(an2), .dp(dp2),
        .digit_tick(tick2), .blink_phase(phase2)
    );

    int vectors  = 0;
    int miscomps = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscomps++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int         n   = 0;     // enabled cycles elapsed
    int         cyc = 0;     // clock edges since reset release
    logic       enq = 1'b0;
    logic       adv = 1'b0;
    logic [3:0] bq  = 4'd0;
    logic [3:0] dq  = 4'd0;
    bit         check_on = 1'b0;

    int         m_cnt, m_slot, m_sel, m_ph;
    logic       m_lit;
    logic [3:0] m_an;
    logic       m_dp, m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; cyc = 0; enq = 1'b0; adv = 1'b0; bq = 4'd0; dq = 4'd0;
        end else begin
            adv = enq;
            if (enq) n++;
            enq = en;
            bq  = blink_mask;
            dq  = dp_mask;
            cyc++;
        end
        #1;
        if (check_on) begin
            m_cnt  = n % SD;
            m_slot = n / SD;
            m_sel  = m_slot % 4;
            m_ph   = (m_slot / 4 / BF) % 2;
            m_lit  = enq && (m_cnt >= G) && !(bq[m_sel] && (m_ph == 1));
            m_an   = m_lit ? ~(4'b0001 << m_sel) : 4'b1111;
            m_dp   = !(m_lit && dq[m_sel]);
            m_tick = adv && (m_cnt == 0);
            vectors++;
            if (sel !== 2'(m_sel) || an !== m_an || dp !== m_dp ||
                digit_tick !== m_tick || blink_phase !== 1'(m_ph)) begin
                miscomps++;
                $display("FAIL model cyc=%0d: got sel=%0d an=%b dp=%b tick=%b ph=%b, expected sel=%0d an=%b dp=%b tick=%b ph=%0d",
                         cyc, sel, an, dp, digit_tick, blink_phase,
                         m_sel, m_an, m_dp, m_tick, m_ph);
            end
            if ($countones(~an) > 1) begin
                miscomps++;
                $display("FAIL onehot: got an=%b, expected at most one low", an);
            end
        end
    end

    // ---------------- second instance: tick period / one-hot ----------------
    int c2    = 0;
    int last2 = -1;
    int nt2   = 0;
    bit done2 = 1'b0;

    initial begin
        rst2_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst2_n = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (rst2_n && !done2) begin
            c2++;
            if ($countones(~an2) > 1) begin
                miscomps++;
                $display("FAIL onehot2: got an=%b, expected at most one low", an2);
            end
            if (tick2) begin
                if (last2 >= 0) chk("tick_period", c2 - last2, SD2);
                chk("tick_sel", int'(sel2), (nt2 + 1) % 4);
                chk("dp2_off", int'(dp2), 1);
                chk("phase2", int'(phase2), 0);
                last2 = c2;
                nt2++;
                if (nt2 == 5) done2 = 1'b1;
            end
        end
    end

    // ---------------- directed stimulus with literal pins ----------------
    task automatic goto(input int k);
        int g = 0;
        do begin
            @(posedge clk);
            #2;
            g++;
        end while (cyc < k && g < 2000);
        chk($sformatf("reach_cyc_%0d", k), cyc, k);
    endtask

    task automatic scan_pins();
        goto(2);
        chk("s1_an_slot0", int'(an), 4'b1110);
        chk("s1_sel_slot0", int'(sel), 0);
        goto(5);
        chk("s1_sel_slot1", int'(sel), 1);
        chk("s1_tick_slot1", int'(digit_tick), 1);
        chk("s1_guard_slot1", int'(an), 4'b1111);
        goto(6);
        chk("s1_an_slot1", int'(an), 4'b1101);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; blink_mask = 4'd0; dp_mask = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", int'(an), 4'b1111);
        chk("reset_dp", int'(dp), 1);
        chk("reset_tick", int'(digit_tick), 0);
        chk("reset_sel", int'(sel), 0);
        check_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Scan order
        scan_pins();

        // Blink on digits 0 and 1
        goto(20);
        blink_mask = 4'b0011;
        goto(33);
        chk("s2_phase_on", int'(blink_phase), 1);
        chk("s2_sel0", int'(sel), 0);
        goto(34);
        chk("s2_slot0_dark", int'(an), 4'b1111);
        goto(42);
        chk("s2_slot2_lit", int'(an), 4'b1011);

        // Decimal point on digit 2
        goto(44);
        dp_mask = 4'b0100;
        goto(57);
        chk("s3_dp_guard", int'(dp), 1);
        goto(58);
        chk("s3_dp_on", int'(dp), 0);
        chk("s3_an_slot2", int'(an), 4'b1011);

        // Enable gating: en_q drops while cnt=2 in slot 1
        goto(70);
        en = 1'b0;
        goto(71);
        chk("s4_an_off", int'(an), 4'b1111);
        chk("s4_dp_off", int'(dp), 1);
        chk("s4_sel_hold", int'(sel), 1);
        goto(81);
        chk("s4_sel_still1", int'(sel), 1);
        chk("s4_no_tick", int'(digit_tick), 0);
        en = 1'b1;
        goto(83);
        chk("s4_finish_slot1", int'(sel), 1);
        goto(84);
        chk("s4_sel2", int'(sel), 2);
        chk("s4_tick", int'(digit_tick), 1);

        // Async reset mid-cycle in slot 3 with blink_phase=1
        goto(121);
        #1;
        chk("s5_pre_phase", int'(blink_phase), 1);
        chk("s5_pre_sel", int'(sel), 3);
        rst_n = 1'b0;
        #1;
        chk("s5_async_an", int'(an), 4'b1111);
        chk("s5_async_sel", int'(sel), 0);
        chk("s5_async_phase", int'(blink_phase), 0);
        blink_mask = 4'd0;
        dp_mask = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scan_pins();
        goto(40);

        // Wait for the second instance to finish its tick measurements
        for (int i = 0; i < 20000 && !done2; i++) @(posedge clk);
        chk("dut2_done", int'(done2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end

endmodule
